// File: rtl/result_pair_accumulator_pkg.sv
// Shared types and width helpers for the result-pair accumulator.
package res_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int sum_w(input int res_w, input int window);
    return res_w + $clog2(window);
  endfunction

endpackage

// File: rtl/result_pair_accumulator_lane.sv
// One lane of the window accumulator: running unsigned sum and maximum.
module lane_accum #(
  parameter int RES_W = 6,
  parameter int SUM_W = 11
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] res,
  output logic [SUM_W-1:0] acc_sum,
  output logic [RES_W-1:0] acc_max
);

  // Clear wins over enable so a reset or a released window never folds in a sample.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_sum <= '0;
      acc_max <= '0;
    end else if (en) begin
      acc_sum <= acc_sum + SUM_W'(res);
      if (res > acc_max) acc_max <= res;
    end
  end

endmodule

// File: rtl/result_pair_accumulator.sv
// Collects windows of result pairs and presents per-lane sum/max and count via valid/ready.
module result_pair_accumulator
  import res_acc_pkg::*;
#(
  parameter  int RES_W  = 6,
  parameter  int WINDOW = 20,
  localparam int CNT_W  = cnt_w(WINDOW),
  localparam int SUM_W  = sum_w(RES_W, WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] result1,
  input  logic [RES_W-1:0] result2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum1,
  output logic [SUM_W-1:0] sum2,
  output logic [RES_W-1:0] max1,
  output logic [RES_W-1:0] max2,
  output logic [CNT_W-1:0] out_count
);

  state_t           state_p0;
  state_t           state_d;
  logic [CNT_W-1:0] count_p0;
  logic             accept;
  logic             full;
  logic             release_win;
  logic             clr;

  assign accept      = in_valid && in_ready;
  assign full        = (int'(count_p0) + 1 == WINDOW);
  assign release_win = (state_p0 == HOLD) && out_ready;
  assign clr         = rst || release_win;

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_d;
  end

  // A flush with no accepted sample only closes a window that already holds data.
  always_comb begin
    state_d = state_p0;
    case (state_p0)
      IDLE, ACCUM: begin
        if (accept && (full || flush))       state_d = HOLD;
        else if (accept)                     state_d = ACCUM;
        else if (flush && state_p0 == ACCUM) state_d = HOLD;
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state_p0 == HOLD) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr)         count_p0 <= '0;
    else if (accept) count_p0 <= count_p0 + CNT_W'(1);
  end

  assign out_count = count_p0;

  lane_accum #(.RES_W(RES_W), .SUM_W(SUM_W)) u_lane1 (
    .clk     (clk),
    .clr     (clr),
    .en      (accept),
    .res     (result1),
    .acc_sum (sum1),
    .acc_max (max1)
  );

  lane_accum #(.RES_W(RES_W), .SUM_W(SUM_W)) u_lane2 (
    .clk     (clk),
    .clr     (clr),
    .en      (accept),
    .res     (result2),
    .acc_sum (sum2),
    .acc_max (max2)
  );

endmodule

// File: tb/tb_result_pair_accumulator.sv
// Directed table plus gapped-traffic model check for result_pair_accumulator (WINDOW=4 and WINDOW=1).
module tb_result_pair_accumulator;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WINDOW=4 instance
  logic       rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [5:0] result1, result2, max1, max2;
  logic [7:0] sum1, sum2;
  logic [2:0] out_count;

  result_pair_accumulator #(.RES_W(6), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result1(result1), .result2(result2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum1(sum1), .sum2(sum2), .max1(max1), .max2(max2), .out_count(out_count)
  );

  // WINDOW=1 instance
  logic       rst1, iv1, ir1, fl1, ov1, or1;
  logic [5:0] r1a, r1b, s1a, s1b, m1a, m1b;
  logic [0:0] c1;

  result_pair_accumulator #(.RES_W(6), .WINDOW(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
    .result1(r1a), .result2(r1b), .flush(fl1),
    .out_valid(ov1), .out_ready(or1),
    .sum1(s1a), .sum2(s1b), .max1(m1a), .max2(m1b), .out_count(c1)
  );

  typedef struct {
    logic       rst, iv, fl, ordy;
    logic [5:0] r1, r2;
    logic       ir, ov;
    logic [7:0] s1, s2;
    logic [5:0] m1, m2;
    logic [2:0] c;
  } vec_t;

  vec_t tbl[29];
  int   nvec  = 0;
  int   nfail = 0;

  function automatic vec_t mk(input logic rst_, iv_, fl_, or_, input int r1_, r2_,
                              input logic ir_, ov_, input int s1_, s2_, m1_, m2_, c_);
    vec_t t;
    t.rst = rst_; t.iv = iv_; t.fl = fl_; t.ordy = or_;
    t.r1 = 6'(r1_); t.r2 = 6'(r2_);
    t.ir = ir_; t.ov = ov_;
    t.s1 = 8'(s1_); t.s2 = 8'(s2_);
    t.m1 = 6'(m1_); t.m2 = 6'(m2_);
    t.c = 3'(c_);
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [32:0] act, input logic [32:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: got ir/ov/s1/s2/m1/m2/c=%b/%b/%0d/%0d/%0d/%0d/%0d want %b/%b/%0d/%0d/%0d/%0d/%0d",
               name, idx, act[32], act[31], act[30:23], act[22:15], act[14:9], act[8:3], act[2:0],
               exp[32], exp[31], exp[30:23], exp[22:15], exp[14:9], exp[8:3], exp[2:0]);
    end
  endtask

  function automatic logic [32:0] dut_out();
    return {in_ready, out_valid, sum1, sum2, max1, max2, out_count};
  endfunction

  // Reference model state for the gapped-traffic run
  logic m_hold;
  int   m_cnt, m_s1, m_s2, m_m1, m_m2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; result1 = '0; result2 = '0;
    rst1 = 1'b1; iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b0; r1a = '0; r1b = '0;

    tbl[0]  = mk(1,0,0,0,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[1]  = mk(0,1,0,0, 10, 1, 1,0,  10,  1, 10, 1, 1);
    tbl[2]  = mk(0,1,0,0, 20, 2, 1,0,  30,  3, 20, 2, 2);
    tbl[3]  = mk(0,1,0,0, 30, 3, 1,0,  60,  6, 30, 3, 3);
    tbl[4]  = mk(0,1,0,0, 63, 4, 0,1, 123, 10, 63, 4, 4);
    for (int i = 5; i <= 9; i++)
      tbl[i] = mk(0,1,0,0, 5, 5, 0,1, 123, 10, 63, 4, 4);
    tbl[10] = mk(0,0,0,1,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[11] = mk(0,1,0,0,  7, 5, 1,0,   7,  5,  7, 5, 1);
    tbl[12] = mk(0,1,1,0,  9, 5, 0,1,  16, 10,  9, 5, 2);
    tbl[13] = mk(0,0,0,1,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[14] = mk(0,0,1,0,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[15] = mk(0,0,0,0,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[16] = mk(0,1,0,0,  3,60, 1,0,   3, 60,  3,60, 1);
    tbl[17] = mk(0,0,1,0,  0, 0, 0,1,   3, 60,  3,60, 1);
    tbl[18] = mk(0,1,1,0,  9, 9, 0,1,   3, 60,  3,60, 1);
    tbl[19] = mk(0,0,0,1,  0, 0, 1,0,   0,  0,  0, 0, 0);
    tbl[20] = mk(0,1,0,0,  1, 2, 1,0,   1,  2,  1, 2, 1);
    tbl[21] = mk(0,1,0,0,  3, 4, 1,0,   4,  6,  3, 4, 2);
    tbl[22] = mk(0,1,0,0,  5, 6, 1,0,   9, 12,  5, 6, 3);
    tbl[23] = mk(1,1,0,0, 50,50, 1,0,   0,  0,  0, 0, 0);
    tbl[24] = mk(0,1,0,0, 63,63, 1,0,  63, 63, 63,63, 1);
    tbl[25] = mk(0,1,0,0, 63,63, 1,0, 126,126, 63,63, 2);
    tbl[26] = mk(0,1,0,0, 63,63, 1,0, 189,189, 63,63, 3);
    tbl[27] = mk(0,1,0,0, 63,63, 0,1, 252,252, 63,63, 4);
    tbl[28] = mk(0,0,0,1,  0, 0, 1,0,   0,  0,  0, 0, 0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; in_valid = tbl[i].iv; flush = tbl[i].fl; out_ready = tbl[i].ordy;
      result1 = tbl[i].r1; result2 = tbl[i].r2;
      @(posedge clk); #1;
      check("table", i, dut_out(),
            {tbl[i].ir, tbl[i].ov, tbl[i].s1, tbl[i].s2, tbl[i].m1, tbl[i].m2, tbl[i].c});
    end

    // Gapped traffic with random backpressure and occasional flush
    m_hold = 1'b0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_m1 = 0; m_m2 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rst = 1'b0;
      in_valid  = ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      flush     = ($urandom_range(5) == 0);
      result1   = 6'($urandom_range(63));
      result2   = 6'($urandom_range(63));
      @(posedge clk);
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_m1 = 0; m_m2 = 0;
        end
      end else begin
        if (in_valid) begin
          m_cnt++;
          m_s1 += int'(result1); m_s2 += int'(result2);
          if (int'(result1) > m_m1) m_m1 = int'(result1);
          if (int'(result2) > m_m2) m_m2 = int'(result2);
        end
        if (in_valid && m_cnt == 4)   m_hold = 1'b1;
        else if (flush && m_cnt > 0)  m_hold = 1'b1;
      end
      #1;
      check("gapped", i, dut_out(),
            {!m_hold, m_hold, 8'(m_s1), 8'(m_s2), 6'(m_m1), 6'(m_m2), 3'(m_cnt)});
    end

    // WINDOW=1: continuous data with a ready consumer alternates HOLD and IDLE
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("w1_reset", 0, {ir1, ov1, 2'b00, s1a, 2'b00, s1b, m1a, m1b, 2'b00, c1},
          {1'b1, 1'b0, 8'd0, 8'd0, 6'd0, 6'd0, 3'd0});
    @(negedge clk);
    rst1 = 1'b0; iv1 = 1'b1; or1 = 1'b1; r1a = 6'd63; r1b = 6'd7;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 1)
        check("w1_hold", k, {ir1, ov1, 2'b00, s1a, 2'b00, s1b, m1a, m1b, 2'b00, c1},
              {1'b0, 1'b1, 8'd63, 8'd7, 6'd63, 6'd7, 3'd1});
      else
        check("w1_idle", k, {ir1, ov1, 2'b00, s1a, 2'b00, s1b, m1a, m1b, 2'b00, c1},
              {1'b1, 1'b0, 8'd0, 8'd0, 6'd0, 6'd0, 3'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
